// File: rtl/cpu_axi_bridge.sv
`default_nettype none
// cpu_axi_bridge: single-outstanding bridge from the core's SRAM-style inst/data ports to AXI.
// Define BRIDGE_AW_W_PARALLEL_EN to issue AW and W together instead of back to back.
module cpu_axi_bridge (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        inst_sram_en,
   input  logic [31:0] inst_sram_addr,
   output logic [31:0] inst_sram_rdata,
   input  logic        data_sram_en,
   input  logic [3:0]  data_sram_wen,
   input  logic [31:0] data_sram_addr,
   input  logic [31:0] data_sram_wdata,
   output logic [31:0] data_sram_rdata,
   output logic        stallreq,
   output logic [3:0]  arid,
   output logic [31:0] araddr,
   output logic        arvalid,
   input  logic        arready,
   input  logic [3:0]  rid,
   input  logic [31:0] rdata,
   input  logic        rvalid,
   output logic        rready,
   output logic [3:0]  awid,
   output logic [31:0] awaddr,
   output logic        awvalid,
   input  logic        awready,
   output logic [31:0] wdata,
   output logic [3:0]  wstrb,
   output logic        wlast,
   output logic        wvalid,
   input  logic        wready,
   input  logic        bvalid,
   output logic        bready
);
   typedef enum logic [2:0] {
      IDLE    = 3'd0,
      RD_ADDR = 3'd1,
      RD_DATA = 3'd2,
      WR_ADDR = 3'd3,
      WR_DATA = 3'd4,
      WR_RESP = 3'd5
   } state_t;

   state_t      state;
   logic        inst_done;
   logic        data_done;
   logic [31:0] req_addr;
   logic        inst_pend;
   logic        data_pend;

   assign inst_pend = inst_sram_en & ~inst_done;
   assign data_pend = data_sram_en & ~data_done;
   assign stallreq  = inst_pend | data_pend;

   // One address register serves both channels; only one transaction is ever in flight.
   assign araddr = req_addr;
   assign awaddr = req_addr;
   assign awid   = 4'd1;
   assign wlast  = 1'b1;

`ifdef BRIDGE_AW_W_PARALLEL_EN
   logic aw_ok;
   logic w_ok;
   logic aw_fin;
   logic w_fin;
   assign aw_fin = aw_ok | (awvalid & awready);
   assign w_fin  = w_ok  | (wvalid & wready);
`endif

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state           <= IDLE;
         inst_done       <= 1'b0;
         data_done       <= 1'b0;
         req_addr        <= 32'd0;
         arid            <= 4'd0;
         arvalid         <= 1'b0;
         rready          <= 1'b0;
         awvalid         <= 1'b0;
         wvalid          <= 1'b0;
         wdata           <= 32'd0;
         wstrb           <= 4'd0;
         bready          <= 1'b0;
         inst_sram_rdata <= 32'd0;
         data_sram_rdata <= 32'd0;
`ifdef BRIDGE_AW_W_PARALLEL_EN
         aw_ok           <= 1'b0;
         w_ok            <= 1'b0;
`endif
      end else begin
         // The core moves on in any cycle it is not stalled, so its requests are new next cycle.
         if (!stallreq) begin
            inst_done <= 1'b0;
            data_done <= 1'b0;
         end
         case (state)
            IDLE: begin
               if (data_pend) begin
                  req_addr <= data_sram_addr;
                  arid     <= 4'd1;
                  wdata    <= data_sram_wdata;
                  wstrb    <= data_sram_wen;
                  if (data_sram_wen == 4'd0) begin
                     arvalid <= 1'b1;
                     state   <= RD_ADDR;
                  end else begin
                     awvalid <= 1'b1;
`ifdef BRIDGE_AW_W_PARALLEL_EN
                     wvalid  <= 1'b1;
`endif
                     state   <= WR_ADDR;
                  end
               end else if (inst_pend) begin
                  req_addr <= inst_sram_addr;
                  arid     <= 4'd0;
                  arvalid  <= 1'b1;
                  state    <= RD_ADDR;
               end
            end
            RD_ADDR: begin
               if (arready) begin
                  arvalid <= 1'b0;
                  rready  <= 1'b1;
                  state   <= RD_DATA;
               end
            end
            RD_DATA: begin
               if (rvalid) begin
                  rready <= 1'b0;
                  if (rid == 4'd1) begin
                     data_sram_rdata <= rdata;
                     data_done       <= 1'b1;
                  end else begin
                     inst_sram_rdata <= rdata;
                     inst_done       <= 1'b1;
                  end
                  state <= IDLE;
               end
            end
`ifdef BRIDGE_AW_W_PARALLEL_EN
            WR_ADDR: begin
               if (awvalid && awready) begin
                  awvalid <= 1'b0;
                  aw_ok   <= 1'b1;
               end
               if (wvalid && wready) begin
                  wvalid <= 1'b0;
                  w_ok   <= 1'b1;
               end
               if (aw_fin && w_fin) begin
                  aw_ok  <= 1'b0;
                  w_ok   <= 1'b0;
                  bready <= 1'b1;
                  state  <= WR_RESP;
               end
            end
            WR_DATA: state <= IDLE;
`else
            WR_ADDR: begin
               if (awready) begin
                  awvalid <= 1'b0;
                  wvalid  <= 1'b1;
                  state   <= WR_DATA;
               end
            end
            WR_DATA: begin
               if (wready) begin
                  wvalid <= 1'b0;
                  bready <= 1'b1;
                  state  <= WR_RESP;
               end
            end
`endif
            WR_RESP: begin
               if (bvalid) begin
                  bready    <= 1'b0;
                  data_done <= 1'b1;
                  state     <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end
endmodule
`default_nettype wire

// File: tb/tb_cpu_axi_bridge.sv
`default_nettype none
// tb_cpu_axi_bridge: directed stimulus against a small AXI slave model with expected-transaction queues.
module tb_cpu_axi_bridge;
   logic        clk;
   logic        rst_n;
   logic        inst_sram_en;
   logic [31:0] inst_sram_addr;
   logic [31:0] inst_sram_rdata;
   logic        data_sram_en;
   logic [3:0]  data_sram_wen;
   logic [31:0] data_sram_addr;
   logic [31:0] data_sram_wdata;
   logic [31:0] data_sram_rdata;
   logic        stallreq;
   logic [3:0]  arid;
   logic [31:0] araddr;
   logic        arvalid;
   logic        arready = 1'b1;
   logic [3:0]  rid;
   logic [31:0] rdata;
   logic        rvalid;
   logic        rready;
   logic [3:0]  awid;
   logic [31:0] awaddr;
   logic        awvalid;
   logic        awready;
   logic [31:0] wdata;
   logic [3:0]  wstrb;
   logic        wlast;
   logic        wvalid;
   logic        wready;
   logic        bvalid;
   logic        bready;

`ifdef BRIDGE_AW_W_PARALLEL_EN
   localparam int   T3_LAT = 7;
   localparam int   T4_LAT = 6;
   localparam int   T5_LAT = 8;
   localparam logic W_FIRST = 1'b1;
`else
   localparam int   T3_LAT = 8;
   localparam int   T4_LAT = 7;
   localparam int   T5_LAT = 9;
   localparam logic W_FIRST = 1'b0;
`endif

   int vectors = 0;
   int miscompares = 0;

   logic [35:0] exp_ar[$];
   logic [31:0] exp_aw[$];
   logic [35:0] exp_w[$];

   int   aw_stall = 0;
   int   w_stall = 0;
   logic r_hold = 1'b0;
   int   aw_total = 0;
   int   w_total = 0;
   int   b_total = 0;
   logic aw_saw_w = 1'b0;

   cpu_axi_bridge dut (
      .clk(clk), .rst_n(rst_n),
      .inst_sram_en(inst_sram_en), .inst_sram_addr(inst_sram_addr), .inst_sram_rdata(inst_sram_rdata),
      .data_sram_en(data_sram_en), .data_sram_wen(data_sram_wen), .data_sram_addr(data_sram_addr),
      .data_sram_wdata(data_sram_wdata), .data_sram_rdata(data_sram_rdata), .stallreq(stallreq),
      .arid(arid), .araddr(araddr), .arvalid(arvalid), .arready(arready),
      .rid(rid), .rdata(rdata), .rvalid(rvalid), .rready(rready),
      .awid(awid), .awaddr(awaddr), .awvalid(awvalid), .awready(awready),
      .wdata(wdata), .wstrb(wstrb), .wlast(wlast), .wvalid(wvalid), .wready(wready),
      .bvalid(bvalid), .bready(bready)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [31:0] mem(input logic [31:0] a);
      return (a == 32'hBFC00000) ? 32'h3C080001 : (a ^ 32'h13579BDF);
   endfunction

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   // Slave model and channel monitor: sample at the edge, respond 1 time unit later.
   always @(posedge clk) begin : slave
      logic        s_ar, s_r, s_aw, s_w, s_b, aw_pre, w_pre, got_aw, got_w;
      logic [35:0] ar_cap;
      logic [35:0] dummy;
      int          aw_cnt, w_cnt;
      s_ar   = arvalid & arready;
      s_r    = rvalid & rready;
      s_aw   = awvalid & awready;
      s_w    = wvalid & wready;
      s_b    = bvalid & bready;
      aw_pre = awvalid;
      w_pre  = wvalid;
      ar_cap = {arid, araddr};
      if (s_ar) begin
         check("ar_expected", exp_ar.size() != 0, 1);
         if (exp_ar.size() != 0) check("ar_id_addr", ar_cap, exp_ar.pop_front());
      end
      if (awvalid) begin
         check("aw_expected", exp_aw.size() != 0, 1);
         if (exp_aw.size() != 0) begin
            check("aw_id_addr_stable", {awid, awaddr}, {4'd1, exp_aw[0]});
            if (s_aw) dummy = {4'd0, exp_aw.pop_front()};
         end
         if (s_aw) begin
            aw_total++;
            aw_saw_w = got_w;
         end
      end
      if (wvalid) begin
         check("w_expected", exp_w.size() != 0, 1);
         if (exp_w.size() != 0) begin
            check("w_last_strb_data", {wlast, wstrb, wdata}, {1'b1, exp_w[0]});
            if (s_w) dummy = exp_w.pop_front();
         end
         if (s_w) w_total++;
      end
      if (bready) check("bready_after_aw_w", {awvalid, wvalid}, 2'b00);
      if (s_b) b_total++;
      #1;
      if (!rst_n) begin
         rvalid  = 1'b0;
         rid     = 4'd0;
         rdata   = 32'd0;
         bvalid  = 1'b0;
         awready = 1'b0;
         wready  = 1'b0;
         got_aw  = 1'b0;
         got_w   = 1'b0;
         aw_cnt  = 0;
         w_cnt   = 0;
      end else begin
         if (s_r) rvalid = 1'b0;
         if (s_ar && !r_hold) begin
            rvalid = 1'b1;
            rid    = ar_cap[35:32];
            rdata  = mem(ar_cap[31:0]);
         end
         if (s_aw) got_aw = 1'b1;
         if (s_w)  got_w  = 1'b1;
         if (s_b)  bvalid = 1'b0;
         if (got_aw && got_w) begin
            bvalid = 1'b1;
            got_aw = 1'b0;
            got_w  = 1'b0;
         end
         if (!aw_pre || s_aw) begin
            aw_cnt  = 0;
            awready = (aw_stall == 0);
         end else if (!awready) begin
            aw_cnt++;
            if (aw_cnt >= aw_stall) awready = 1'b1;
         end
         if (!w_pre || s_w) begin
            w_cnt  = 0;
            wready = (w_stall == 0);
         end else if (!wready) begin
            w_cnt++;
            if (w_cnt >= w_stall) wready = 1'b1;
         end
      end
   end

   task automatic run_req(input logic ie, input logic [31:0] ia, input logic de, input logic [3:0] dw,
                          input logic [31:0] da, input logic [31:0] dd, output int cyc);
      @(negedge clk);
      inst_sram_en    = ie;
      inst_sram_addr  = ia;
      data_sram_en    = de;
      data_sram_wen   = dw;
      data_sram_addr  = da;
      data_sram_wdata = dd;
      cyc = 0;
      do begin
         @(negedge clk);
         cyc++;
      end while (stallreq && cyc < 100);
      check("stall_released", stallreq, 0);
      inst_sram_en = 1'b0;
      data_sram_en = 1'b0;
   endtask

   initial begin : watchdog
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin : stim
      int cyc, aw0, w0, b0;
      rst_n = 1'b0;
      inst_sram_en = 1'b0;  inst_sram_addr = 32'd0;
      data_sram_en = 1'b0;  data_sram_wen = 4'd0;
      data_sram_addr = 32'd0; data_sram_wdata = 32'd0;
      repeat (3) @(negedge clk);
      check("rst_arvalid", arvalid, 0);
      check("rst_rready", rready, 0);
      check("rst_awvalid", awvalid, 0);
      check("rst_wvalid", wvalid, 0);
      check("rst_bready", bready, 0);
      check("rst_stallreq", stallreq, 0);
      check("rst_inst_rdata", inst_sram_rdata, 0);
      check("rst_data_rdata", data_sram_rdata, 0);
      check("rst_araddr", araddr, 0);
      rst_n = 1'b1;

      // Lone instruction fetch, zero-wait slave.
      exp_ar.push_back({4'd0, 32'hBFC00000});
      run_req(1'b1, 32'hBFC00000, 1'b0, 4'd0, 32'd0, 32'd0, cyc);
      check("t1_latency", cyc, 3);
      check("t1_inst_rdata", inst_sram_rdata, 32'h3C080001);

      // Fetch and load together: data goes first.
      exp_ar.push_back({4'd1, 32'h80001000});
      exp_ar.push_back({4'd0, 32'hBFC00004});
      run_req(1'b1, 32'hBFC00004, 1'b1, 4'd0, 32'h80001000, 32'd0, cyc);
      check("t2_latency", cyc, 6);
      check("t2_inst_rdata", inst_sram_rdata, mem(32'hBFC00004));
      check("t2_data_rdata", data_sram_rdata, mem(32'h80001000));
      check("t2_ar_all_seen", exp_ar.size(), 0);

      // Halfword store with awready held off.
      aw_stall = 4; w_stall = 0;
      aw0 = aw_total; w0 = w_total; b0 = b_total;
      exp_aw.push_back(32'h80002000);
      exp_w.push_back({4'b0011, 32'hDEADBEEF});
      run_req(1'b0, 32'd0, 1'b1, 4'b0011, 32'h80002000, 32'hDEADBEEF, cyc);
      check("t3_latency", cyc, T3_LAT);
      check("t3_b_before_release", b_total - b0, 1);
      check("t3_aw_count", aw_total - aw0, 1);
      check("t3_w_count", w_total - w0, 1);
      check("t3_data_rdata_hold", data_sram_rdata, mem(32'h80001000));
      check("t3_inst_rdata_hold", inst_sram_rdata, mem(32'hBFC00004));

      // wready ready long before awready.
      aw_stall = 3; w_stall = 0;
      aw0 = aw_total; w0 = w_total; b0 = b_total;
      exp_aw.push_back(32'h80002010);
      exp_w.push_back({4'b1000, 32'hA5A5A5A5});
      run_req(1'b0, 32'd0, 1'b1, 4'b1000, 32'h80002010, 32'hA5A5A5A5, cyc);
      check("t4_latency", cyc, T4_LAT);
      check("t4_w_before_aw", aw_saw_w, W_FIRST);
      check("t4_aw_count", aw_total - aw0, 1);
      check("t4_w_count", w_total - w0, 1);
      check("t4_b_count", b_total - b0, 1);

      // Store plus fetch, wready held off.
      aw_stall = 0; w_stall = 2;
      aw0 = aw_total; w0 = w_total;
      exp_aw.push_back(32'h80004000);
      exp_w.push_back({4'b1111, 32'h12345678});
      exp_ar.push_back({4'd0, 32'hBFC0000C});
      run_req(1'b1, 32'hBFC0000C, 1'b1, 4'b1111, 32'h80004000, 32'h12345678, cyc);
      check("t5_latency", cyc, T5_LAT);
      check("t5_inst_rdata", inst_sram_rdata, mem(32'hBFC0000C));
      check("t5_aw_count", aw_total - aw0, 1);
      check("t5_w_count", w_total - w0, 1);
      check("t5_queues_empty", exp_ar.size() + exp_aw.size() + exp_w.size(), 0);

      // Reset while waiting in RD_DATA.
      w_stall = 0; r_hold = 1'b1;
      exp_ar.push_back({4'd0, 32'hBFC00008});
      @(negedge clk);
      inst_sram_en = 1'b1; inst_sram_addr = 32'hBFC00008;
      cyc = 0;
      do begin
         @(negedge clk);
         cyc++;
      end while (!rready && cyc < 20);
      check("t6_reached_rd_data", rready, 1);
      rst_n = 1'b0;
      #1;
      check("t6_rst_arvalid", arvalid, 0);
      check("t6_rst_rready", rready, 0);
      check("t6_rst_araddr", araddr, 0);
      check("t6_rst_inst_rdata", inst_sram_rdata, 0);
      check("t6_rst_data_rdata", data_sram_rdata, 0);
      inst_sram_en = 1'b0;
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      r_hold = 1'b0;
      exp_ar.push_back({4'd1, 32'h80003000});
      run_req(1'b0, 32'd0, 1'b1, 4'd0, 32'h80003000, 32'd0, cyc);
      check("t6_fresh_latency", cyc, 3);
      check("t6_fresh_data_rdata", data_sram_rdata, mem(32'h80003000));
      check("t6_inst_rdata_clear", inst_sram_rdata, 0);
      check("final_queues_empty", exp_ar.size() + exp_aw.size() + exp_w.size(), 0);

      repeat (2) @(negedge clk);
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule
`default_nettype wire
